// File: rtl/registered_n_to_1_mux.sv
// N-channel, W-bit selector with a registered output stage and valid/ready
// handshakes. The grant is either a fixed sel index or round-robin over requesters.
module registered_n_to_1_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int SEL_SPAN = 2 ** SEL_W;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    last_q, last_d;

  logic                load_en;
  logic [SEL_SPAN-1:0] valid_ext;
  logic                fx_valid;
  logic                rr_valid;
  logic [SEL_W-1:0]    rr_grant;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant;
  logic [WIDTH-1:0]    grant_word;

  assign load_en = !valid_q || out_ready;

  // Padding the request vector to the full index span makes sel >= CHANNELS
  // read as "not requesting" without an out-of-range index.
  assign valid_ext = SEL_SPAN'(in_valid);
  assign fx_valid  = valid_ext[sel];

  // Scan from farthest to nearest offset so the nearest requester after last wins.
  always_comb begin
    int idx;
    rr_valid = 1'b0;
    rr_grant = '0;
    for (int off = CHANNELS; off >= 1; off--) begin
      idx = (int'(last_q) + off) % CHANNELS;
      if (in_valid[idx]) begin
        rr_valid = 1'b1;
        rr_grant = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (mode) begin
      grant_valid = rr_valid;
      grant       = rr_grant;
    end else begin
      grant_valid = fx_valid;
      grant       = sel;
    end
  end

  assign grant_word = grant_valid ? in_data[int'(grant)*WIDTH +: WIDTH] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && load_en && grant_valid && (grant == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_en) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        data_d = grant_word;
        chan_d = grant;
        last_d = grant;
      end
    end
  end

  // last resets to the top channel so the first round-robin search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_registered_n_to_1_mux.sv
// Directed bench for registered_n_to_1_mux (WIDTH=8, CHANNELS=4) with
// hand-computed expectations for reset, fixed, round-robin and backpressure cases.
module tb_registered_n_to_1_mux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [WIDTH*CHANNELS-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  int checks_cnt;
  int errors_cnt;

  registered_n_to_1_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    in_data = {w3, w2, w1, w0};
  endtask

  initial begin
    logic [1:0] rr_exp [8];
    logic [1:0] sp_exp [4];
    logic [7:0] base_w [4];
    checks_cnt = 0;
    errors_cnt = 0;
    base_w = '{8'h10, 8'h11, 8'h12, 8'h13};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    sp_exp = '{2'd3, 2'd1, 2'd3, 2'd1};

    // Reset state with every channel requesting
    rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_valid = 4'b1111;
    set_words(8'h10, 8'h11, 8'h12, 8'h13);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_chan",  32'(out_chan),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Round-robin with all valid: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_ready_%0d", i), 32'(in_ready), 32'(4'b0001 << rr_exp[i]));
      tick();
      chk($sformatf("rr_chan_%0d", i), 32'(out_chan), 32'(rr_exp[i]));
      chk($sformatf("rr_data_%0d", i), 32'(out_data), 32'(base_w[rr_exp[i]]));
      chk($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'd1);
    end

    // Fixed select: sel=2, ch2 carries 0xA5
    mode = 1'b0; sel = 2'd2;
    set_words(8'h10, 8'h11, 8'hA5, 8'h13);
    #1;
    chk("fx_ready", 32'(in_ready), 32'h4);
    tick();
    chk("fx_data", 32'(out_data), 32'hA5);
    chk("fx_chan", 32'(out_chan), 32'd2);
    set_words(8'h10, 8'h11, 8'h12, 8'h13);

    // Fixed select of channel 1 leaves last=1 for the sparse round-robin case
    sel = 2'd1;
    tick();
    chk("fx1_chan", 32'(out_chan), 32'd1);
    mode = 1'b1; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("sp_ready_%0d", i), 32'(in_ready), 32'(4'b0001 << sp_exp[i]));
      tick();
      chk($sformatf("sp_chan_%0d", i), 32'(out_chan), 32'(sp_exp[i]));
    end

    // Backpressure: load 0x3C from ch0 then stall five cycles
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
    set_words(8'h3C, 8'h11, 8'h12, 8'h13);
    tick();
    chk("bp_load_data", 32'(out_data), 32'h3C);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(i);
      mode = i[0];
      set_words(8'(8'h40 + i), 8'h51, 8'h62, 8'h73);
      #1;
      chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("bp_data_%0d", i), 32'(out_data), 32'h3C);
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_chan_%0d", i), 32'(out_chan), 32'd0);
    end
    // Drain and refill on the same edge from ch3
    out_ready = 1'b1; mode = 1'b0; sel = 2'd3;
    set_words(8'h10, 8'h11, 8'h12, 8'h77);
    #1;
    chk("bp_rel_ready", 32'(in_ready), 32'h8);
    tick();
    chk("bp_rel_data",  32'(out_data),  32'h77);
    chk("bp_rel_chan",  32'(out_chan),  32'd3);
    chk("bp_rel_valid", 32'(out_valid), 32'd1);

    // Invalid select: sel=1 while ch1 idle
    sel = 2'd1; in_valid = 4'b1101;
    set_words(8'h10, 8'h11, 8'h12, 8'h13);
    #1;
    chk("inv_ready", 32'(in_ready), 32'd0);
    tick();
    chk("inv_valid", 32'(out_valid), 32'd0);
    chk("inv_data",  32'(out_data),  32'h77);
    chk("inv_chan",  32'(out_chan),  32'd3);
    #1;
    chk("inv_ready2", 32'(in_ready), 32'd0);
    tick();
    chk("inv_valid2", 32'(out_valid), 32'd0);

    // Mid-stream reset: last=3 so round-robin gives ch0 then ch1
    mode = 1'b1; in_valid = 4'b1111;
    tick();
    chk("mid_chan0", 32'(out_chan), 32'd0);
    tick();
    chk("mid_chan1", 32'(out_chan), 32'd1);
    chk("mid_data1", 32'(out_data), 32'h11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_chan",  32'(out_chan),  32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    chk("post_rst_chan",  32'(out_chan),  32'd0);
    chk("post_rst_data",  32'(out_data),  32'h10);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/registered_n_to_1_mux.md
# registered_n_to_1_mux

Parametrised N-channel, W-bit selector with a registered output and valid/ready handshakes on every input and on the output. It generalises the team's fixed 8-bit 2:1 structural multiplexer. It adds two select modes: fixed select, and round-robin arbitration across requesting channels. It sits between multiple producer stages and a single consumer in the datapath, and provides one-cycle latency and full throughput.

## Interface
- WIDTH, 8, data width per channel (≥1)
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, $clog2(CHANNELS), derived width of channel index; not to be overridden
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset is asynchronous and active-low
- in_data  input  WIDTH*CHANNELS  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  bit k: channel k offers a word
- in_ready  output  CHANNELS  bit k: channel k's word is accepted this cycle
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_chan hold a word
- out_ready  input  1  consumer accepts the output word

## Operation
- Transfer on channel k: in_valid[k] && in_ready[k] at a rising edge. Output transfer: out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register may be written only when load_en is 1.
- Grant, mode=0: the grant goes to channel sel when in_valid[sel]=1. There is no grant when in_valid[sel]=0 or when sel ≥ CHANNELS.
- Grant, mode=1: search starts at channel (last+1) mod CHANNELS and wraps upward. The first channel with in_valid set is granted. There is no grant when in_valid is all zeros.
- in_ready[k] = load_en && grant_valid && (grant == k). At most one in_ready bit is high at any time. in_ready is combinational from in_valid, sel, mode and out_ready.
- On an edge with load_en and grant_valid:
  - out_data ← word of the granted channel
  - out_chan ← grant
  - out_valid ← 1
  - last ← grant (in both modes)
- On an edge with load_en and no grant: out_valid ← 0. out_data and out_chan hold their values.
- When load_en=0, all output state holds. The output word must stay stable while out_valid=1 and out_ready=0.
- Changing mode or sel affects only the next grant. It never alters or drops a word already held in the output register.
- Channels that are not granted never lose data. They must hold in_valid and in_data until they see their in_ready.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, last=CHANNELS-1 (so the first round-robin search starts at channel 0). in_ready is all zeros while rst_n is low.
- Reset deassertion takes effect synchronously at the next edge. The first grant can occur on the first edge after rst_n goes high.
- Reset mid-operation: the held word is discarded and out_valid drops immediately. No in_ready is asserted while reset is active.
- Latency: a word accepted at edge n is visible on out_data with out_valid=1 after edge n, i.e. one cycle.
- Throughput: one word per cycle while out_ready=1 and any channel is valid. Simultaneous output drain and refill occur on the same edge.
- Round-robin fairness: with all channels continuously valid, a given channel is granted exactly once every CHANNELS transfers.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0 and in_ready=0 immediately. After release with all valid in round-robin mode, the first grant is channel 0.
- Fixed mode, WIDTH=8, CHANNELS=4: mode=0, sel=2, in_valid=4'b1111, ch2 data 0xA5, out_ready=1 → one edge later out_data=0xA5, out_chan=2. Only in_ready[2] is high.
- Round-robin: mode=1, all channels valid, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3.
- Sparse round-robin: in_valid=4'b1010 held with last=1 → grants alternate 3,1,3,1. Channels 0 and 2 never receive in_ready.
- Backpressure: out_valid=1 holding 0x3C, out_ready=0 for 5 cycles while inputs and sel change → out_data stays 0x3C and in_ready stays all zeros. On the cycle out_ready returns to 1, drain and refill occur on the same edge.
- Invalid select: mode=0, sel=1 with in_valid[1]=0 (other channels valid), out_ready=1 → no in_ready asserted, and out_valid falls to 0 after the pending word drains.
